// File: rtl/program_store.sv
// Instruction RAM with a framed byte-stream loader (LEN | 4*N bytes | CSUM).
// The processor is enabled only once a checksum-verified program is resident.
//
// state | meaning
// IDLE  | after reset, nothing loaded, stream not accepted
// LEN   | waiting for the length byte (N-1)
// DATA  | assembling little-endian instruction bytes into RAM words
// CSUM  | waiting for the XOR checksum byte
// RUN   | program verified, processor enabled
// ERR   | checksum mismatch, processor held off
module program_store #(
  parameter int ADDR_WIDTH   = 8,
  parameter int INSTRS_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic [INSTRS_WIDTH-1:0] instr,
  output logic                    proc_ena,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   last_addr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [INSTRS_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [1:0]              byte_idx;
  logic [23:0]             asm_reg;
  logic [7:0]              csum;
  logic                    xfer;
  logic                    wr_en;
  logic                    word_last;

  assign xfer      = s_valid & s_ready;
  assign word_last = (byte_idx == 2'd3);
  assign wr_en     = (state == DATA) & xfer & word_last & ~load_start & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = IDLE;
      LEN:  if (xfer) state_nxt = DATA;
      DATA: if (xfer && word_last && (wr_addr == last_addr)) state_nxt = CSUM;
      CSUM: if (xfer) state_nxt = (s_data == csum) ? RUN : ERR;
      RUN:  state_nxt = RUN;
      ERR:  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
    if (load_start) state_nxt = LEN;
  end

  always_comb begin
    s_ready  = 1'b0;
    busy     = 1'b0;
    proc_ena = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      LEN, DATA, CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      RUN: begin
        proc_ena = 1'b1;
        done     = 1'b1;
      end
      ERR: err = 1'b1;
      default: ;
    endcase
  end

  // A restart throws away any partially assembled word and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr <= '0;
      wr_addr   <= '0;
      byte_idx  <= '0;
      asm_reg   <= '0;
      csum      <= '0;
    end else if (load_start) begin
      wr_addr  <= '0;
      byte_idx <= '0;
      asm_reg  <= '0;
      csum     <= '0;
    end else if (xfer) begin
      case (state)
        LEN: begin
          last_addr <= ADDR_WIDTH'(s_data);
          csum      <= s_data;
          wr_addr   <= '0;
          byte_idx  <= '0;
        end
        DATA: begin
          csum     <= csum ^ s_data;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    asm_reg[7:0]   <= s_data;
            2'd1:    asm_reg[15:8]  <= s_data;
            2'd2:    asm_reg[23:16] <= s_data;
            default: ;
          endcase
          if (word_last && (wr_addr != last_addr)) wr_addr <= wr_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {s_data, asm_reg};
  end

  assign instr = (proc_ena && (pc <= last_addr)) ? mem[pc] : '0;

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store: reset, good/bad frames, gaps, abort and full depth.
module tb_program_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic        proc_ena;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  last_addr;

  int checks = 0;
  int errors = 0;

  program_store #(.ADDR_WIDTH(8), .INSTRS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pc(pc), .instr(instr), .proc_ena(proc_ena), .busy(busy),
    .done(done), .err(err), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic read_at(input logic [7:0] a, input string tag, input logic [31:0] exp);
    pc = a;
    #1;
    check(tag, instr, exp);
  endtask

  logic [7:0] frame2 [0:9];

  initial begin
    frame2[0] = 8'h01;
    frame2[1] = 8'h02; frame2[2] = 8'h00; frame2[3] = 8'h00; frame2[4] = 8'h00;
    frame2[5] = 8'h05; frame2[6] = 8'h00; frame2[7] = 8'h00; frame2[8] = 8'h00;
    frame2[9] = 8'h06;

    rst = 1'b1; load_start = 1'b0; s_data = 8'h00; s_valid = 1'b1; pc = '0;
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_proc_ena", 32'(proc_ena), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_addr", 32'(last_addr), 32'd0);
    read_at(8'd0, "rst_instr_pc0", 32'h0);
    read_at(8'd255, "rst_instr_pc255", 32'h0);
    rst = 1'b0;
    s_valid = 1'b0;
    tick();
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // Normal N=2 load
    pulse_load();
    check("n2_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) check("n2_busy_mid", 32'(busy), 32'd1);
      send_byte(frame2[i], 0);
    end
    check("n2_proc_ena", 32'(proc_ena), 32'd1);
    check("n2_done", 32'(done), 32'd1);
    check("n2_busy_end", 32'(busy), 32'd0);
    check("n2_s_ready_run", 32'(s_ready), 32'd0);
    check("n2_last_addr", 32'(last_addr), 32'd1);
    read_at(8'd0, "n2_pc0", 32'h00000002);
    read_at(8'd1, "n2_pc1", 32'h00000005);
    read_at(8'd2, "n2_pc2", 32'h00000000);

    // Bad checksum
    pulse_load();
    check("bad_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 9; i++) send_byte(frame2[i], 0);
    send_byte(8'h07, 0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_proc_ena", 32'(proc_ena), 32'd0);
    read_at(8'd0, "bad_instr", 32'h0);
    tick();
    check("bad_err_sticky", 32'(err), 32'd1);
    pulse_load();
    check("bad_err_cleared", 32'(err), 32'd0);
    check("bad_busy_reload", 32'(busy), 32'd1);

    // Same frame with random gaps, already in LEN
    for (int i = 0; i < 10; i++) send_byte(frame2[i], int'($urandom_range(0, 5)));
    check("gap_done", 32'(done), 32'd1);
    check("gap_last_addr", 32'(last_addr), 32'd1);
    read_at(8'd0, "gap_pc0", 32'h00000002);
    read_at(8'd1, "gap_pc1", 32'h00000005);
    read_at(8'd2, "gap_pc2", 32'h00000000);

    // Abort after 6 DATA bytes, then N=1 frame
    pulse_load();
    for (int i = 0; i < 7; i++) send_byte(frame2[i], 0);
    check("abort_busy", 32'(busy), 32'd1);
    pulse_load();
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h00, 0);
    send_byte(8'h37, 0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_err", 32'(err), 32'd0);
    check("abort_last_addr", 32'(last_addr), 32'd0);
    read_at(8'd0, "abort_pc0", 32'h00123411);
    read_at(8'd1, "abort_pc1", 32'h00000000);

    // Full depth, word k = {k,k,k,k}; each word XORs to 0 so CSUM = LEN = FF
    pulse_load();
    send_byte(8'hFF, 0);
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < 4; j++) send_byte(8'(k), 0);
    check("full_busy_csum", 32'(busy), 32'd1);
    send_byte(8'hFF, 0);
    check("full_done", 32'(done), 32'd1);
    check("full_last_addr", 32'(last_addr), 32'd255);
    read_at(8'd0, "full_pc0", 32'h00000000);
    read_at(8'd255, "full_pc255", 32'hFFFFFFFF);
    read_at(8'd128, "full_pc128", 32'h80808080);
    read_at(8'd1, "full_pc1", 32'h01010101);

    // Reset mid-load discards everything
    pulse_load();
    send_byte(8'h00, 0);
    rst = 1'b1;
    load_start = 1'b1;
    tick();
    rst = 1'b0;
    load_start = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_last_addr", 32'(last_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_store.md
Name: program_store

Overview:
- Instruction memory and byte-stream loader feeding the washing-machine processor.
- Receives a framed program over an 8-bit valid/ready byte stream from the host link and writes it into a 2^ADDR_WIDTH x INSTRS_WIDTH RAM.
- Answers the processor's pc with instr combinationally.
- Holds the processor disabled (proc_ena low) until a complete, checksum-verified program is resident.

Parameters:
- ADDR_WIDTH, 8, pc / write-address width; depth = 2^ADDR_WIDTH.
- INSTRS_WIDTH, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- load_start  in  1  single-cycle pulse; begins (or restarts) a program load
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts a byte this cycle
- pc  in  ADDR_WIDTH  processor fetch address
- instr  out  INSTRS_WIDTH  instruction at pc (combinational)
- proc_ena  out  1  processor enable; high only in RUN
- busy  out  1  load in progress (LEN, DATA or CSUM)
- done  out  1  verified program resident (equals proc_ena)
- err  out  1  last load failed its checksum; sticky until next load_start or rst
- last_addr  out  ADDR_WIDTH  index of the last loaded instruction

Behaviour:
- Byte transfer occurs only when s_valid & s_ready are both high. s_ready is registered-state driven: 1 in LEN, DATA and CSUM, 0 otherwise.
- Frame format, in order:
  - LEN byte = N-1, where N is 1..256 instructions.
  - 4*N instruction bytes, little-endian; byte0 is the opcode, i.e. instr[7:0].
  - CSUM byte = XOR of the LEN byte and all instruction bytes.
- States:
  - IDLE (reset): s_ready=0.
  - LEN: on transfer, last_addr<=byte, csum<=byte, wr_addr<=0, byte_idx<=0 -> DATA.
  - DATA: each transfer XORs the byte into csum and shifts it into the assembly register at lane byte_idx, then byte_idx increments modulo 4.
    - On the transfer with byte_idx==3, mem[wr_addr] is written with {byte, b2, b1, b0} in that cycle.
    - If wr_addr==last_addr -> CSUM; else wr_addr increments.
  - CSUM: on transfer, byte==csum -> RUN; mismatch -> ERR.
  - RUN: proc_ena=done=1. Stays until load_start.
  - ERR: err=1, proc_ena=0. Stays until load_start.
- load_start in any state (including mid-frame):
  - next state LEN; proc_ena, done and err clear on the next cycle.
  - assembly state and csum are discarded.
  - RAM words already written are not cleared.
- load_start is ignored in the cycle rst is high. rst has priority over everything; rst mid-load discards the frame.
- Reset values: state=IDLE, s_ready=0, proc_ena=0, busy=0, done=0, err=0, last_addr=0, internal counters 0. RAM contents are not reset.
- Read path:
  - instr = mem[pc] when proc_ena=1 and pc<=last_addr.
  - instr = 0 otherwise, including pc beyond the program and all non-RUN states.
  - Zero latency, no register.
- Write and read never overlap, because proc_ena=0 while loading.
- wr_addr is ADDR_WIDTH bits. With N=256, the terminal compare is wr_addr==last_addr==2^ADDR_WIDTH-1, so no wrap occurs before CSUM.
- A LEN transfer in the same cycle as load_start: load_start wins and the byte is dropped, because s_ready is computed from the current state, and state restarts to LEN.

Test Plan:
- Reset: assert rst 2 cycles with s_valid=1 -> s_ready=0, proc_ena=0, done=0, err=0, busy=0, instr=0 for any pc.
- Normal load, N=2:
  - Stimulus: load_start, then stream 01 | 02 00 00 00 | 05 00 00 00 | 06.
  - Required: busy high during the frame; proc_ena=done=1 the cycle after CSUM; last_addr=1.
  - Reads: pc=0 -> 0x00000002, pc=1 -> 0x00000005, pc=2 -> 0x00000000.
- Bad checksum: same frame with CSUM 07 -> err=1, proc_ena=0, instr=0. A following load_start clears err next cycle.
- Backpressure/gaps: same frame with s_valid deasserted for random 0-5 cycles between bytes -> identical final memory and RUN; no byte double-counted.
- Abort mid-frame: load_start after 6 DATA bytes, then the full N=1 frame 00 | 11 34 12 00 | 37 -> RUN, last_addr=0, pc=0 -> 0x00123411.
- Full depth: N=256 (LEN FF), word k = {k, k, k, k}, correct XOR CSUM -> RUN. pc=0 -> 0x00000000, pc=255 -> 0xFFFFFFFF, pc=128 -> 0x80808080.
